// File: rtl/frame_mixer_rr_pkg.sv
// Shared types and constants for the frame-aware round-robin mixer.
//   state_t       : mixer FSM states (IDLE / READ / ABORT)
//   FLAG_BIT_DEF  : default bit position of the frame-data flag
//   TERM_WORD     : word written when a frame has to be closed by abort
//   wrap_inc()    : modulo-n increment used for the round-robin pointer
package frame_mixer_rr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  localparam int FLAG_BIT_DEF = 8;

  // Widest supported word; the top slices it down to DW bits.
  localparam logic [31:0] TERM_WORD = 32'h0000_0000;

  function automatic int wrap_inc(input int cur, input int n);
    return ((cur + 1) >= n) ? 0 : (cur + 1);
  endfunction

endpackage

// File: rtl/frame_mixer_rr_if.sv
// Bus bundle between the mixer, its ingress FIFOs and its egress FIFO.
//   in_dout   : ingress FIFO data, port p at [p*DW +: DW]
//   in_empty  : ingress FIFO empty flags
//   in_rd_en  : ingress read strobes (one-hot or zero)
//   port_en   : per-port grant enable
//   din/wr_en : egress FIFO write data / strobe
//   full      : egress prog-full (>=2 free entries still left when high)
// master = the mixer, slave = the FIFO side.
interface frame_mixer_rr_if #(
  parameter int NPORTS = 4,
  parameter int DW     = 9
);
  logic [NPORTS*DW-1:0] in_dout;
  logic [NPORTS-1:0]    in_empty;
  logic [NPORTS-1:0]    in_rd_en;
  logic [NPORTS-1:0]    port_en;
  logic [DW-1:0]        din;
  logic                 full;
  logic                 wr_en;

  modport master (
    input  in_dout, in_empty, port_en, full,
    output in_rd_en, din, wr_en
  );

  modport slave (
    output in_dout, in_empty, port_en, full,
    input  in_rd_en, din, wr_en
  );
endinterface

// File: rtl/frame_mixer_rr_arbiter.sv
// Combinational round-robin search.
//   req   : request vector, one bit per port
//   ptr   : port with highest priority this round
//   grant : first requesting port at or above ptr (wrapping)
//   hit   : any request present
module frame_mixer_rr_arbiter #(
  parameter  int NPORTS = 4,
  localparam int PW     = $clog2(NPORTS)
) (
  input  logic [NPORTS-1:0] req,
  input  logic [PW-1:0]     ptr,
  output logic [PW-1:0]     grant,
  output logic              hit
);

  // Scan upward from ptr, first requester wins.
  always_comb begin
    int idx_v;
    grant = '0;
    hit   = 1'b0;
    idx_v = 0;
    for (int i = 0; i < NPORTS; i++) begin
      idx_v = (int'(ptr) + i) % NPORTS;
      if (!hit && req[idx_v[PW-1:0]]) begin
        hit   = 1'b1;
        grant = idx_v[PW-1:0];
      end else begin
        hit = hit;
      end
    end
  end

endmodule

// File: rtl/frame_mixer_rr.sv
// Frame-aware round-robin mixer: merges NPORTS ingress FIFOs into one
// egress FIFO without interleaving frames.
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   bus              : ingress/egress FIFO bundle (master side)
//   cur_port         : currently granted port
//   busy             : a port is granted
//   frame_abort      : one-cycle pulse with the terminator of a timed-out frame
module frame_mixer_rr
  import frame_mixer_rr_pkg::*;
#(
  parameter  int NPORTS   = 4,
  parameter  int DW       = 9,
  parameter  int FLAG_BIT = FLAG_BIT_DEF,
  parameter  int TIMEOUT  = 1024,
  localparam int PW       = $clog2(NPORTS)
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  frame_mixer_rr_if.master bus,
  output logic [PW-1:0]    cur_port,
  output logic             busy,
  output logic             frame_abort
);

  // Counter only has to reach TIMEOUT-1.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  state_t            state_r, state_nx_s;
  logic [PW-1:0]     rr_ptr_r, cur_port_r, grant_s;
  logic              busy_r, seen_data_r, valid_q_r, wr_en_r, frame_abort_r, hit_s;
  logic [DW-1:0]     din_r, word_q_s;
  logic [CW-1:0]     tmo_cnt_r;
  logic [NPORTS-1:0] req_s, rd_onehot_s;
  logic              cur_empty_s, term_q_s, rd_s, tmo_run_s, tmo_hit_s;

  assign req_s       = bus.port_en & ~bus.in_empty;
  // Word read last cycle from the granted port (valid when valid_q_r).
  assign word_q_s    = bus.in_dout[int'(cur_port_r)*DW +: DW];
  assign cur_empty_s = bus.in_empty[cur_port_r];
  // Flag-0 word only terminates once real frame data has been seen.
  assign term_q_s    = valid_q_r && !word_q_s[FLAG_BIT] && seen_data_r;
  // Stop reading as soon as the terminator is in hand; never over-read.
  assign rd_s        = (state_r == ST_READ) && !cur_empty_s && !bus.full && !term_q_s;
  assign tmo_run_s   = (state_r == ST_READ) && seen_data_r && cur_empty_s;
  assign tmo_hit_s   = (TIMEOUT != 0) && tmo_run_s && (tmo_cnt_r == CW'(TIMEOUT - 1));

  frame_mixer_rr_arbiter #(.NPORTS(NPORTS)) u_arb (
    .req   (req_s),
    .ptr   (rr_ptr_r),
    .grant (grant_s),
    .hit   (hit_s)
  );

  // FSM state register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic; terminator wins over timeout.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (hit_s) state_nx_s = ST_READ;
        else       state_nx_s = ST_IDLE;
      end
      ST_READ: begin
        if (term_q_s)       state_nx_s = ST_IDLE;
        else if (tmo_hit_s) state_nx_s = ST_ABORT;
        else                state_nx_s = ST_READ;
      end
      ST_ABORT: begin
        if (!bus.full) state_nx_s = ST_IDLE;
        else           state_nx_s = ST_ABORT;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // FSM outputs: read strobe to the granted port only.
  always_comb begin
    rd_onehot_s = '0;
    if (rd_s) begin
      rd_onehot_s[cur_port_r] = 1'b1;
    end else begin
      rd_onehot_s = '0;
    end
  end

  // Grant bookkeeping: current port, busy, rr pointer, seen-data flag.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rr_ptr_r    <= '0;
      cur_port_r  <= '0;
      busy_r      <= 1'b0;
      seen_data_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (hit_s) begin
            cur_port_r  <= grant_s;
            busy_r      <= 1'b1;
            seen_data_r <= 1'b0;
          end
        end
        ST_READ: begin
          if (term_q_s) begin
            rr_ptr_r    <= PW'(wrap_inc(int'(cur_port_r), NPORTS));
            busy_r      <= 1'b0;
            seen_data_r <= 1'b0;
          end else if (valid_q_r && word_q_s[FLAG_BIT]) begin
            seen_data_r <= 1'b1;
          end
        end
        ST_ABORT: begin
          if (!bus.full) begin
            rr_ptr_r <= PW'(wrap_inc(int'(cur_port_r), NPORTS));
            busy_r   <= 1'b0;
          end
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  // Mid-frame starvation counter; any read restarts it.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tmo_cnt_r <= '0;
    end else if ((state_r != ST_READ) || rd_s || tmo_hit_s) begin
      tmo_cnt_r <= '0;
    end else if (tmo_run_s) begin
      tmo_cnt_r <= tmo_cnt_r + CW'(1);
    end
  end

  // Egress pipeline: every word read is written one cycle later. An abort
  // cannot collide with an in-flight word because it only fires after the
  // port has been empty (no reads) for at least one cycle.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      valid_q_r     <= 1'b0;
      din_r         <= '0;
      wr_en_r       <= 1'b0;
      frame_abort_r <= 1'b0;
    end else begin
      valid_q_r <= rd_s;
      if (valid_q_r) begin
        din_r         <= word_q_s;
        wr_en_r       <= 1'b1;
        frame_abort_r <= 1'b0;
      end else if ((state_r == ST_ABORT) && !bus.full) begin
        din_r         <= TERM_WORD[DW-1:0];
        wr_en_r       <= 1'b1;
        frame_abort_r <= 1'b1;
      end else begin
        wr_en_r       <= 1'b0;
        frame_abort_r <= 1'b0;
      end
    end
  end

  assign bus.in_rd_en = rd_onehot_s;
  assign bus.din      = din_r;
  assign bus.wr_en    = wr_en_r;
  assign cur_port     = cur_port_r;
  assign busy         = busy_r;
  assign frame_abort  = frame_abort_r;

endmodule

// File: tb/tb_frame_mixer_rr.sv
// Randomized bench for frame_mixer_rr: FIFO models on both sides, a
// frame-level round-robin reference model producing the expected egress
// word stream, and per-cycle protocol checks.
module tb_frame_mixer_rr;

  localparam int NP = 4;
  localparam int DW = 9;

  typedef logic [DW-1:0] wq_t[$];

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [1:0] cur_port;
  logic       busy;
  logic       frame_abort;

  frame_mixer_rr_if #(.NPORTS(NP), .DW(DW)) bus ();

  frame_mixer_rr #(.NPORTS(NP), .DW(DW), .FLAG_BIT(8), .TIMEOUT(16)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .bus         (bus),
    .cur_port    (cur_port),
    .busy        (busy),
    .frame_abort (frame_abort)
  );

  initial forever #5 sys_clk = ~sys_clk;

  wq_t           fq[NP];        // ingress FIFO contents seen by the DUT
  wq_t           mq[NP];        // same words, consumed by the reference model
  int            frames_left[NP];
  logic [DW:0]   expq[$];       // expected egress {frame_abort, din}
  logic [DW-1:0] dout_r[NP];
  logic [NP-1:0] rd_snap, en_s;
  logic          full_s, full_prev, rst_req;
  bit            full_mode, no_p1;
  int            cyc, n_total, n_bad, model_ptr, wr_count, abort_cnt;
  int            wr_cyc_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_word(input int p, input logic [DW-1:0] w);
    fq[p].push_back(w);
    mq[p].push_back(w);
  endtask

  task automatic load_frame(input int p, input int ngap, input int ndata);
    for (int i = 0; i < ngap; i++) push_word(p, {1'b0, 8'($urandom_range(0, 255))});
    for (int i = 0; i < ndata; i++) push_word(p, {1'b1, 8'($urandom_range(0, 255))});
    push_word(p, {1'b0, 8'($urandom_range(0, 255))});
    frames_left[p]++;
  endtask

  // Reference: whole frames leave in round-robin order over enabled ports.
  task automatic build_expected(input logic [NP-1:0] en);
    bit found;
    do begin
      found = 1'b0;
      for (int i = 0; i < NP && !found; i++) begin
        int p;
        p = (model_ptr + i) % NP;
        if (en[p] && frames_left[p] > 0) begin
          bit seen, done;
          logic [DW-1:0] w;
          seen = 1'b0;
          done = 1'b0;
          while (!done) begin
            w = mq[p].pop_front();
            expq.push_back({1'b0, w});
            if (w[8]) seen = 1'b1;
            else if (seen) done = 1'b1;
          end
          frames_left[p]--;
          model_ptr = (p + 1) % NP;
          found = 1'b1;
        end
      end
    end while (found);
  endtask

  // One clock: FIFO pops, output checks, new inputs, read-strobe checks.
  task automatic step();
    logic [DW:0] e;
    @(negedge sys_clk);
    cyc++;
    for (int p = 0; p < NP; p++) begin
      if (rd_snap[p] && fq[p].size() > 0) dout_r[p] = fq[p].pop_front();
    end
    if (bus.wr_en) begin
      wr_count++;
      wr_cyc_q.push_back(cyc);
      if (frame_abort) abort_cnt++;
      if (expq.size() == 0) begin
        check_eq("unexpected_wr", 32'(bus.wr_en), 32'd0);
      end else begin
        e = expq.pop_front();
        check_eq("egress", 32'({frame_abort, bus.din}), 32'(e));
      end
    end else begin
      check_eq("abort_wo_wr", 32'(frame_abort), 32'd0);
    end
    if (bus.full && full_prev) check_eq("wr_after_full", 32'(bus.wr_en), 32'd0);
    if (no_p1 && busy) check_eq("p1_granted", 32'(cur_port == 2'd1), 32'd0);
    full_prev = bus.full;
    if (full_mode && $urandom_range(0, 4) == 0) full_s = !full_s;
    bus.full    = full_s;
    bus.port_en = en_s;
    sys_rst     = rst_req;
    for (int p = 0; p < NP; p++) begin
      bus.in_dout[p*DW +: DW] = dout_r[p];
      bus.in_empty[p]         = (fq[p].size() == 0);
    end
    #1;
    rd_snap = bus.in_rd_en;
    check_eq("rd_onehot", 32'($countones(rd_snap) <= 1), 32'd1);
    check_eq("rd_on_empty", 32'(rd_snap & bus.in_empty), 32'd0);
    if (bus.full) check_eq("rd_while_full", 32'(rd_snap), 32'd0);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((expq.size() != 0 || busy) && n < 3000) begin
      step();
      n++;
    end
    check_eq(tag, 32'(expq.size()), 32'd0);
    check_eq("busy_after_drain", 32'(busy), 32'd0);
    repeat (3) step();
  endtask

  task automatic check_reset(input string pfx);
    check_eq({pfx, "_din"}, 32'(bus.din), 32'd0);
    check_eq({pfx, "_wr_en"}, 32'(bus.wr_en), 32'd0);
    check_eq({pfx, "_rd_en"}, 32'(bus.in_rd_en), 32'd0);
    check_eq({pfx, "_cur_port"}, 32'(cur_port), 32'd0);
    check_eq({pfx, "_busy"}, 32'(busy), 32'd0);
    check_eq({pfx, "_abort"}, 32'(frame_abort), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base;
    n_total = 0; n_bad = 0; cyc = 0; wr_count = 0; abort_cnt = 0; model_ptr = 0;
    rst_req = 1'b1; en_s = 4'b1111; full_s = 1'b0; full_prev = 1'b0;
    full_mode = 1'b0; no_p1 = 1'b0; rd_snap = '0;
    for (int p = 0; p < NP; p++) begin
      dout_r[p] = '0;
      frames_left[p] = 0;
    end
    repeat (3) step();
    check_reset("rst");
    rst_req = 1'b0;
    step();

    // Single frame 1AA,1BB,000 on port 0: three back-to-back writes.
    push_word(0, 9'h1AA); push_word(0, 9'h1BB); push_word(0, 9'h000);
    frames_left[0]++;
    build_expected(en_s);
    wr_cyc_q.delete();
    drain("t1_drain");
    check_eq("t1_nwr", 32'(wr_cyc_q.size()), 32'd3);
    if (wr_cyc_q.size() == 3) check_eq("t1_back2back", 32'(wr_cyc_q[2] - wr_cyc_q[0]), 32'd2);

    // One short frame per port.
    for (int p = 0; p < NP; p++) load_frame(p, 0, 1);
    build_expected(en_s);
    drain("t2_drain");

    // Backpressure for 5 cycles in the middle of a long frame.
    load_frame(0, 0, 8);
    build_expected(en_s);
    base = wr_count;
    n = 0;
    while (wr_count < base + 3 && n < 100) begin step(); n++; end
    full_s = 1'b1;
    repeat (5) step();
    full_s = 1'b0;
    drain("t3_drain");

    // Random frames with random backpressure.
    full_mode = 1'b1;
    for (int r = 0; r < 6; r++) begin
      for (int p = 0; p < NP; p++) begin
        int nf;
        nf = $urandom_range(0, 3);
        for (int f = 0; f < nf; f++) load_frame(p, $urandom_range(0, 1), $urandom_range(1, 4));
      end
      build_expected(en_s);
      drain("rand_drain");
    end
    full_mode = 1'b0;
    full_s = 1'b0;
    step();

    // Port 1 disabled: never granted; then enabled, its frame follows.
    en_s = 4'b1101;
    load_frame(0, 0, 2); load_frame(0, 1, 1);
    load_frame(1, 0, 2); load_frame(2, 0, 3); load_frame(3, 0, 1);
    step();
    no_p1 = 1'b1;
    build_expected(en_s);
    drain("t5_drain");
    no_p1 = 1'b0;
    en_s = 4'b1111;
    build_expected(en_s);
    drain("t5_p1_drain");

    // Port 1 starves mid-frame: terminator 000 written with frame_abort.
    wr_cyc_q.delete();
    abort_cnt = 0;
    fq[1].push_back(9'h1AA); fq[1].push_back(9'h1BB);
    expq.push_back(10'h1AA); expq.push_back(10'h1BB); expq.push_back(10'h200);
    model_ptr = 2;
    drain("t4_drain");
    check_eq("t4_abort_cnt", 32'(abort_cnt), 32'd1);
    check_eq("t4_nwr", 32'(wr_cyc_q.size()), 32'd3);
    if (wr_cyc_q.size() == 3)
      check_eq("t4_delay_16_18", 32'((wr_cyc_q[2] - wr_cyc_q[1]) >= 16 && (wr_cyc_q[2] - wr_cyc_q[1]) <= 18), 32'd1);

    // Reset in the middle of a frame, then restart from port 0.
    for (int p = 0; p < NP; p++) load_frame(p, 0, 4);
    build_expected(en_s);
    base = wr_count;
    n = 0;
    while (wr_count < base + 2 && n < 100) begin step(); n++; end
    check_eq("t6_midframe", 32'(busy), 32'd1);
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    for (int p = 0; p < NP; p++) begin
      fq[p].delete();
      mq[p].delete();
      frames_left[p] = 0;
    end
    expq.delete();
    model_ptr = 0;
    step();
    check_reset("t6_rst");
    for (int p = NP - 1; p >= 0; p--) load_frame(p, 0, 2);
    build_expected(en_s);
    n = 0;
    while (!busy && n < 20) begin step(); n++; end
    check_eq("t6_busy", 32'(busy), 32'd1);
    check_eq("t6_first_port", 32'(cur_port), 32'd0);
    drain("t6_drain");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
